// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that time-shares one external combinational adder between NREQ requesters.
// Operands are held for SETTLE cycles before the sum is sampled and returned over a valid/ready channel.
module adder_share_arbiter #(
  parameter  int W      = 64,
  parameter  int NREQ   = 4,
  parameter  int SETTLE = 4,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_bus,
  input  logic [NREQ*W-1:0] b_bus,
  output logic [NREQ-1:0]   gnt,
  output logic [W-1:0]      add_a,
  output logic [W-1:0]      add_b,
  input  logic [W-1:0]      add_sum,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_sum,
  input  logic              rsp_ready,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    add_a_q, add_a_d;
  logic [W-1:0]    add_b_q, add_b_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [W-1:0]    rsp_sum_q, rsp_sum_d;

  logic            win_vld;
  logic [IDW-1:0]  win_idx;
  int unsigned     idx;

  // Response channel: a response transfers on any rising edge where rsp_valid and
  // rsp_ready are both high; rsp_id/rsp_sum stay stable while rsp_valid waits for rsp_ready.

  // Winner search starts at ptr and wraps, so the last winner gets lowest priority next.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win_idx = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      rsp_id_q  <= '0;
      rsp_sum_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      rsp_id_q  <= rsp_id_d;
      rsp_sum_q <= rsp_sum_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    add_a_d   = add_a_q;
    add_b_d   = add_b_q;
    rsp_id_d  = rsp_id_q;
    rsp_sum_d = rsp_sum_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          add_a_d  = a_bus[int'(win_idx)*W +: W];
          add_b_d  = b_bus[int'(win_idx)*W +: W];
          rsp_id_d = win_idx;
          cnt_d    = CW'(SETTLE - 1);
          ptr_d    = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        // The adder output is only trusted once operands have been stable SETTLE cycles.
        if (cnt_q == '0) begin
          rsp_sum_d = add_sum;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gnt       = '0;
    rsp_valid = (state_q == S_RESP);
    busy      = (state_q != S_IDLE);
    dbg_state = state_q;
    if (state_q == S_IDLE && win_vld) gnt[win_idx] = 1'b1;
  end

  assign add_a   = add_a_q;
  assign add_b   = add_b_q;
  assign rsp_id  = rsp_id_q;
  assign rsp_sum = rsp_sum_q;

endmodule
